// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/clear sequencer for a cascaded chain of BCD
// digit counter cells. Divides clk into count ticks, builds the per-digit
// cascade enables from the chain's cnt_9 flags, stops the chain at all-9s and
// freezes a lap snapshot for the display driver.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | chain cleared or never started; prescaler held at zero
//   RUN   | prescaler counting, ticks advance the chain
//   PAUSE | prescaler frozen mid-interval, chain holds its value
//   FULL  | chain reached all-9s; counting stopped until clear
//
// Digit cells sample on the falling edge, so a one-cycle tick_r pulse from
// this rising-edge controller contains exactly one sampling edge.

module stopwatch_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      btn_start_stop,
  input  logic                      btn_clear,
  input  logic                      btn_lap,
  input  logic [NUM_DIGITS-1:0]     digit_cnt9,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     dig_en,
  output logic                      cnt_reset,
  output logic [4*NUM_DIGITS-1:0]   display,
  output logic                      running,
  output logic                      lap_active,
  output logic                      overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_FULL  = 2'd3;

  logic [1:0]              state, state_nxt;
  logic [PW-1:0]           presc, presc_nxt;
  logic                    tick_r, tick_nxt;
  logic                    lap_nxt;
  logic [4*NUM_DIGITS-1:0] lap_reg, lap_reg_nxt;
  logic                    cnt_reset_nxt;
  logic                    prev_ss, prev_clr, prev_lap;
  logic                    ss_edge, clr_edge, lap_edge;
  logic                    all_nine;

  assign ss_edge  = btn_start_stop & ~prev_ss;
  assign clr_edge = btn_clear      & ~prev_clr;
  assign lap_edge = btn_lap        & ~prev_lap;
  assign all_nine = &digit_cnt9;

  // Next-state, prescaler, tick and lap decisions; clear overrides everything.
  always_comb begin
    state_nxt     = state;
    presc_nxt     = presc;
    tick_nxt      = 1'b0;
    lap_nxt       = lap_active;
    lap_reg_nxt   = lap_reg;
    cnt_reset_nxt = 1'b0;

    if (clr_edge) begin
      state_nxt     = S_IDLE;
      presc_nxt     = '0;
      lap_nxt       = 1'b0;
      cnt_reset_nxt = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          presc_nxt = '0;
          if (ss_edge) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (ss_edge) begin
            // Pause wins over a coinciding terminal count: prescaler holds.
            state_nxt = S_PAUSE;
          end else if (presc == PRESC_MAX) begin
            presc_nxt = '0;
            if (all_nine) state_nxt = S_FULL;
            else          tick_nxt  = 1'b1;
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
        S_PAUSE: begin
          if (ss_edge) state_nxt = S_RUN;
        end
        default: begin
          presc_nxt = '0;
        end
      endcase

      // Lap is judged against the state before this edge's transition.
      if (lap_edge) begin
        if (state == S_RUN || state == S_PAUSE) begin
          lap_nxt = ~lap_active;
          if (!lap_active) lap_reg_nxt = digits;
        end else if (state == S_FULL) begin
          lap_nxt = 1'b0;
        end
      end
    end
  end

  // Controller registers; reset leaves the chain held in clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      presc      <= '0;
      tick_r     <= 1'b0;
      lap_active <= 1'b0;
      lap_reg    <= '0;
      prev_ss    <= 1'b0;
      prev_clr   <= 1'b0;
      prev_lap   <= 1'b0;
      cnt_reset  <= 1'b1;
      running    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      tick_r     <= tick_nxt;
      lap_active <= lap_nxt;
      lap_reg    <= lap_reg_nxt;
      prev_ss    <= btn_start_stop;
      prev_clr   <= btn_clear;
      prev_lap   <= btn_lap;
      cnt_reset  <= cnt_reset_nxt;
      running    <= (state_nxt == S_RUN);
      overflow   <= (state_nxt == S_FULL);
    end
  end

  // Cascade enables: a digit advances when the tick fires and every lower digit is at 9.
  assign dig_en[0] = tick_r;
  for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_cascade
    assign dig_en[i] = tick_r & (&digit_cnt9[i-1:0]);
  end

  // Display follows the live chain unless a lap snapshot is frozen.
  always_comb begin
    display = lap_active ? lap_reg : digits;
  end

endmodule
